match_game_core: RTL and testbench

//  Parametrised N-player timed sequence-matching game controller. It is the successor to the fixed two-player
//  4-bit game core. Flow: serial password unlock, then NUM_ROUNDS timed rounds. Each round draws an LFSR target;

---
 rtl/match_game_pkg.sv | 22 ++
 rtl/lfsr16.sv | 22 ++
 rtl/match_game_core.sv | 214 +++++++++++++++++++++
 tb/tb_match_game_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/match_game_pkg.sv
// rtl/match_game_pkg.sv - shared state encoding and LFSR constants for the match game
package match_game_pkg;

  localparam int LFSR_W = 16;

  // Taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCKED,
    ST_ARMED,
    ST_GUESS,
    ST_SCORE,
    ST_DONE
  } state_t;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR
module lfsr16
  import match_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;

  // Step once per cycle; reload the seed while in reset
  always_ff @(posedge Clk) begin
    if (Rst) r_q <= SEED;
    else     r_q <= {r_q[LFSR_W-2:0], lfsr_feedback(r_q)};
  end

  assign q = r_q;

endmodule

// File: rtl/match_game_core.sv
// rtl/match_game_core.sv - N-player timed sequence-matching game controller
module match_game_core
  import match_game_pkg::*;
#(
  parameter int                   NUM_PLAYERS  = 2,
  parameter int                   DATA_W       = 4,
  parameter int                   NUM_ROUNDS   = 4,
  parameter int                   ROUND_CYCLES = 50,
  parameter int                   SCORE_W      = 4,
  parameter int                   PASS_LEN     = 6,
  parameter logic [PASS_LEN-1:0]  PASSWORD     = 6'b111111,
  parameter logic [LFSR_W-1:0]    LFSR_SEED    = 16'hACE1
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Start,
  input  logic                              Pas,
  input  logic                              AcsPas,
  input  logic                              AcsRNG,
  input  logic [NUM_PLAYERS-1:0]            AcsP,
  input  logic [NUM_PLAYERS*DATA_W-1:0]     PIn,
  output logic                              Unlocked,
  output logic [DATA_W-1:0]                 Target,
  output logic [$clog2(ROUND_CYCLES+1)-1:0] TimeLeft,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]   Round,
  output logic [NUM_PLAYERS*SCORE_W-1:0]    Score,
  output logic [NUM_PLAYERS-1:0]            Win,
  output logic                              Tie
);

  localparam int TW = $clog2(ROUND_CYCLES+1);
  localparam int RW = $clog2(NUM_ROUNDS+1);
  localparam int CW = $clog2(PASS_LEN+1);

  state_t r_state, w_next;

  logic                          r_pas_prev, r_rng_prev;
  logic [NUM_PLAYERS-1:0]        r_accp_prev;
  logic [CW-1:0]                 r_bit_cnt;
  logic [PASS_LEN-1:0]           r_shift;
  logic [NUM_PLAYERS-1:0]        r_committed;
  logic [DATA_W-1:0]             r_target;
  logic [TW-1:0]                 r_time;
  logic [RW-1:0]                 r_round;
  logic [NUM_PLAYERS*SCORE_W-1:0] r_score;
  logic [NUM_PLAYERS-1:0]        r_win;
  logic                          r_tie;

  logic                          w_pas_rise, w_rng_rise;
  logic [NUM_PLAYERS-1:0]        w_accp_fall, w_commit;
  logic [PASS_LEN:0]             w_shift_wide;
  logic [PASS_LEN-1:0]           w_shift_next;
  logic                          w_pw_last, w_pw_ok;
  logic                          w_all_done, w_time_up, w_abort, w_unlocked;
  logic [RW-1:0]                 w_round_inc;
  logic [NUM_PLAYERS*SCORE_W-1:0] w_score_next;
  logic [SCORE_W-1:0]            w_max;
  logic [3:0]                    w_nmax;
  logic [NUM_PLAYERS-1:0]        w_win;
  logic                          w_tie;
  logic [LFSR_W-1:0]             w_lfsr;
  logic                          w_lfsr_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk (Clk),
    .Rst (Rst),
    .q   (w_lfsr)
  );

  // Only the low DATA_W bits feed the target
  assign w_lfsr_unused = ^w_lfsr;

  assign w_pas_rise   = AcsPas & ~r_pas_prev;
  assign w_rng_rise   = AcsRNG & ~r_rng_prev;
  assign w_accp_fall  = ~AcsP & r_accp_prev;
  assign w_commit     = w_accp_fall & ~r_committed & {NUM_PLAYERS{r_state == ST_GUESS}};
  assign w_all_done   = &(r_committed | w_commit);
  assign w_time_up    = (r_time == TW'(1));
  assign w_shift_wide = {r_shift, Pas};
  assign w_shift_next = w_shift_wide[PASS_LEN-1:0];
  assign w_pw_last    = (r_bit_cnt == CW'(PASS_LEN-1));
  assign w_pw_ok      = (w_shift_next == PASSWORD);
  assign w_abort      = (r_state != ST_IDLE) && !Start;
  assign w_round_inc  = r_round + RW'(1);

  // Next-state and unlock flag
  always_comb begin
    w_next     = r_state;
    w_unlocked = 1'b0;
    if (w_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (Start) w_next = ST_LOCKED;
        ST_LOCKED: if (w_pas_rise && w_pw_last && w_pw_ok) w_next = ST_ARMED;
        ST_ARMED:  if (w_rng_rise) w_next = ST_GUESS;
        ST_GUESS:  if (w_all_done || w_time_up) w_next = ST_SCORE;
        ST_SCORE:  w_next = (w_round_inc == RW'(NUM_ROUNDS)) ? ST_DONE : ST_ARMED;
        ST_DONE:   w_next = ST_DONE;
        default:   w_next = ST_IDLE;
      endcase
    end
    case (r_state)
      ST_ARMED, ST_GUESS, ST_SCORE, ST_DONE: w_unlocked = 1'b1;
      default:                               w_unlocked = 1'b0;
    endcase
  end

  // Score update for this cycle's first commits of matching guesses, saturating
  always_comb begin
    w_score_next = r_score;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (w_commit[i] && (PIn[i*DATA_W +: DATA_W] == r_target) &&
          (r_score[i*SCORE_W +: SCORE_W] != {SCORE_W{1'b1}}))
        w_score_next[i*SCORE_W +: SCORE_W] = r_score[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
    end
  end

  // Winner compare: unique max scorer wins, shared max is a tie
  always_comb begin
    w_max  = '0;
    w_nmax = '0;
    w_win  = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (r_score[i*SCORE_W +: SCORE_W] > w_max) w_max = r_score[i*SCORE_W +: SCORE_W];
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (r_score[i*SCORE_W +: SCORE_W] == w_max) begin
        w_nmax   = w_nmax + 4'd1;
        w_win[i] = 1'b1;
      end
    end
    w_tie = (w_nmax > 4'd1);
    if (w_tie) w_win = '0;
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: edge history, password shifter, timer, scores, result flags
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pas_prev  <= 1'b0;
      r_rng_prev  <= 1'b0;
      r_accp_prev <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_committed <= '0;
      r_target    <= '0;
      r_time      <= '0;
      r_round     <= '0;
      r_score     <= '0;
      r_win       <= '0;
      r_tie       <= 1'b0;
    end else begin
      r_pas_prev  <= AcsPas;
      r_rng_prev  <= AcsRNG;
      r_accp_prev <= AcsP;
      if (w_abort) begin
        r_time <= '0;
        r_win  <= '0;
        r_tie  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (Start) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_score   <= '0;
            r_round   <= '0;
          end
          ST_LOCKED: if (w_pas_rise) begin
            if (w_pw_last) begin
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
              r_shift   <= w_shift_next;
            end
          end
          ST_ARMED: if (w_rng_rise) begin
            r_target    <= w_lfsr[DATA_W-1:0];
            r_time      <= TW'(ROUND_CYCLES);
            r_committed <= '0;
          end
          ST_GUESS: begin
            r_time      <= (w_all_done || w_time_up) ? '0 : r_time - TW'(1);
            r_committed <= r_committed | w_commit;
            r_score     <= w_score_next;
          end
          ST_SCORE: begin
            r_round <= w_round_inc;
            r_time  <= '0;
            if (w_round_inc == RW'(NUM_ROUNDS)) begin
              r_win <= w_win;
              r_tie <= w_tie;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Unlocked = w_unlocked;
  assign Target   = r_target;
  assign TimeLeft = r_time;
  assign Round    = r_round;
  assign Score    = r_score;
  assign Win      = r_win;
  assign Tie      = r_tie;

endmodule

// File: tb/tb_match_game_core.sv
// tb/tb_match_game_core.sv - randomized self-checking bench for match_game_core
module tb_match_game_core;

  localparam int NP = 2;
  localparam int DW = 4;
  localparam int NR = 2;
  localparam int RC = 8;

  logic          Clk = 1'b0;
  logic          Rst, Start, Pas, AcsPas, AcsRNG;
  logic [NP-1:0] AcsP;
  logic [NP*DW-1:0] PIn;

  logic          Unlocked, s_Unlocked;
  logic [DW-1:0] Target, s_Target;
  logic [3:0]    TimeLeft, s_TimeLeft;
  logic [1:0]    Round, s_Round;
  logic [7:0]    Score;
  logic [1:0]    s_Score;
  logic [1:0]    Win, s_Win;
  logic          Tie, s_Tie;

  match_game_core #(.NUM_PLAYERS(NP), .DATA_W(DW), .NUM_ROUNDS(NR), .ROUND_CYCLES(RC),
                    .SCORE_W(4)) u_dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Pas(Pas), .AcsPas(AcsPas), .AcsRNG(AcsRNG),
    .AcsP(AcsP), .PIn(PIn), .Unlocked(Unlocked), .Target(Target), .TimeLeft(TimeLeft),
    .Round(Round), .Score(Score), .Win(Win), .Tie(Tie));

  match_game_core #(.NUM_PLAYERS(NP), .DATA_W(DW), .NUM_ROUNDS(NR), .ROUND_CYCLES(RC),
                    .SCORE_W(1)) u_dut_sat (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Pas(Pas), .AcsPas(AcsPas), .AcsRNG(AcsRNG),
    .AcsP(AcsP), .PIn(PIn), .Unlocked(s_Unlocked), .Target(s_Target), .TimeLeft(s_TimeLeft),
    .Round(s_Round), .Score(s_Score), .Win(s_Win), .Tie(s_Tie));

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  int          m_score[NP];
  int          m_round;

  // Reference LFSR: shift left, new bit = XOR of taps 16,14,13,11
  always @(posedge Clk) begin
    if (Rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int cap(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // {Tie, Win[1:0]} expected from two scores capped at lim
  function automatic logic [2:0] result(input int a0, input int a1, input int lim);
    int a, b;
    a = cap(a0, lim);
    b = cap(a1, lim);
    if (a > b) return 3'b001;
    if (b > a) return 3'b010;
    return 3'b100;
  endfunction

  task automatic send_pw(input logic [5:0] pw, input string tag);
    for (int b = 5; b >= 0; b--) begin
      Pas = pw[b];
      AcsPas = 1'b1;
      tick();
      if (b == 0) check_val(tag, Unlocked, (pw == 6'h3F));
      AcsPas = 1'b0;
      tick();
    end
  endtask

  task automatic new_game();
    Start = 1'b0;
    tick();
    check_val("abort_unlocked", Unlocked, 0);
    check_val("abort_win", {Tie, Win}, 0);
    check_val("abort_score_kept", Score, {m_score[1][3:0], m_score[0][3:0]});
    Start = 1'b1;
    tick();
    check_val("start_clears_score", Score, 0);
    check_val("start_clears_round", Round, 0);
    m_score[0] = 0;
    m_score[1] = 0;
    m_round    = 0;
    send_pw(6'h3F, "relock");
  endtask

  // mode: 0 no guess, 1 match, 2 mismatch, 3 match with repeated release
  // rel : GUESS cycle index of the (first) release; >= RC means never
  task automatic play_round(input int m0, input int m1, input int r0, input int r1);
    int          md[NP], rl[NP], c[NP];
    logic [3:0]  g[NP];
    logic [3:0]  exp_t;
    logic [2:0]  res;
    int          e;
    md[0] = m0; md[1] = m1; rl[0] = r0; rl[1] = r1;
    exp_t = m_lfsr[3:0];
    for (int i = 0; i < NP; i++) begin
      if (md[i] == 2) g[i] = exp_t ^ 4'($urandom_range(1, 15));
      else if (md[i] == 0) g[i] = 4'($urandom);
      else g[i] = exp_t;
      c[i] = (md[i] != 0 && rl[i] < RC) ? rl[i] : -1;
    end
    PIn    = {g[1], g[0]};
    AcsP   = '1;
    AcsRNG = 1'b1;
    tick();
    AcsRNG = 1'b0;
    check_val("target", Target, exp_t);
    e = (c[0] >= 0 && c[1] >= 0) ? ((c[0] > c[1]) ? c[0] : c[1]) : RC - 1;
    for (int k = 0; k <= e; k++) begin
      check_val($sformatf("timeleft_k%0d", k), TimeLeft, RC - k);
      for (int i = 0; i < NP; i++) begin
        if (md[i] != 0) begin
          if (k == rl[i]) AcsP[i] = 1'b0;
          if (md[i] == 3 && k == rl[i] + 1) AcsP[i] = 1'b1;
          if (md[i] == 3 && k == rl[i] + 2) AcsP[i] = 1'b0;
        end
      end
      tick();
    end
    for (int i = 0; i < NP; i++)
      if (c[i] >= 0 && g[i] == exp_t) m_score[i] = cap(m_score[i] + 1, 15);
    m_round++;
    check_val("score_time_zero", TimeLeft, 0);
    check_val("score", Score, {m_score[1][3:0], m_score[0][3:0]});
    check_val("score_sat", s_Score, {cap(m_score[1], 1) != 0, cap(m_score[0], 1) != 0});
    tick();
    check_val("round", Round, m_round);
    check_val("unlocked_in_game", Unlocked, 1);
    if (m_round == NR) begin
      res = result(m_score[0], m_score[1], 15);
      check_val("done_result", {Tie, Win}, res);
      res = result(m_score[0], m_score[1], 1);
      check_val("done_result_sat", {s_Tie, s_Win}, res);
    end else begin
      check_val("no_result_yet", {Tie, Win}, 0);
    end
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Pas = 1'b0; AcsPas = 1'b0; AcsRNG = 1'b0;
    AcsP = '0; PIn = '0;
    m_score[0] = 0; m_score[1] = 0; m_round = 0;
    tick();
    tick();
    check_val("rst_outputs", {Unlocked, Target, TimeLeft, Round, Score, Win, Tie}, 0);
    Rst = 1'b0;
    Start = 1'b1;
    tick();

    // Password: wrong patterns keep it locked, correct one unlocks after retries
    send_pw(6'b111110, "pw_wrong_111110");
    for (int n = 0; n < 2; n++) begin
      logic [5:0] bad;
      bad = 6'($urandom_range(0, 62));
      send_pw(bad, "pw_wrong_rand");
    end
    send_pw(6'h3F, "pw_right");

    // Game 1: P0 hits, P1 misses in the same release cycle; then a silent round
    play_round(1, 2, 3, 3);
    play_round(0, 0, RC, RC);

    // Game 2: both match in both rounds; P0 releases twice in round 1
    new_game();
    play_round(3, 1, 2, 5);
    play_round(1, 1, $urandom_range(0, RC - 1), $urandom_range(0, RC - 1));

    // Game 3: P0 matches twice, saturating the 1-bit score copy
    new_game();
    play_round(1, 0, 1, RC);
    play_round(1, 0, RC - 1, RC);

    // Randomized games
    for (int gm = 0; gm < 4; gm++) begin
      new_game();
      for (int r = 0; r < NR; r++)
        play_round($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, RC + 1), $urandom_range(0, RC + 1));
    end

    // Reset in the middle of round 2 while TimeLeft is 3
    new_game();
    play_round(1, 1, 0, 4);
    PIn = '0; AcsP = '1; AcsRNG = 1'b1;
    tick();
    AcsRNG = 1'b0;
    for (int k = 0; k < RC - 3; k++) tick();
    check_val("mid_timeleft", TimeLeft, 3);
    Rst = 1'b1;
    tick();
    check_val("mid_rst_outputs", {Unlocked, Target, TimeLeft, Round, Score, Win, Tie}, 0);
    check_val("mid_rst_sat", {s_Unlocked, s_Target, s_TimeLeft, s_Round, s_Score, s_Win, s_Tie}, 0);
    Rst = 1'b0;
    m_score[0] = 0; m_score[1] = 0; m_round = 0;
    tick();
    send_pw(6'h3F, "post_rst_unlock");
    play_round(1, 2, 2, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
